// File: rtl/skylark_pkg.sv
// skylark_pkg
//   Shared types and constants for the Skylark fetch unit.
//   - fetch_entry_t : one prefetch queue entry {pc, instr}
//   - NOP_INSTR     : instruction presented when no valid head exists
//   - fetch_state_e : fetch FSM states
//   - alignWord     : forces a byte address to word alignment
package skylark_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    RUN        = 2'd1,
    DRAIN      = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/skylark_sync_fifo.sv
// skylark_sync_fifo
//   Synchronous FIFO with synchronous flush, used as the fetch prefetch queue.
//   Parameters: WIDTH (entry bits), DEPTH (entries, power of two).
//   Ports:
//     clk, reset    : clock, asynchronous active-low reset
//     flush         : empties the FIFO on the next edge (wins over push/pop)
//     push/pushData : write an entry at the tail
//     pop           : remove the head (ignored when empty)
//     popData       : current head entry
//     full, empty   : occupancy flags
//     level         : current occupancy (0..DEPTH)
//   A push while full is accepted when a pop happens in the same cycle.
module skylark_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [LW-1:0]    count_r;
  logic             pushEn_s;
  logic             popEn_s;

  // Accept/consume qualification: pop frees the slot a simultaneous push needs.
  always_comb begin
    popEn_s  = 1'b0;
    pushEn_s = 1'b0;
    if (!empty) begin
      popEn_s = pop;
    end else begin
      popEn_s = 1'b0;
    end
    if (!full || popEn_s) begin
      pushEn_s = push;
    end else begin
      pushEn_s = 1'b0;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else if (flush) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (pushEn_s) begin
        wrPtr_r <= wrPtr_r + AW'(1);
      end
      if (popEn_s) begin
        rdPtr_r <= rdPtr_r + AW'(1);
      end
      case ({pushEn_s, popEn_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (pushEn_s && !flush) begin
      mem_r[wrPtr_r] <= pushData;
    end
  end

  assign popData = mem_r[rdPtr_r];
  assign full    = (count_r == LW'(DEPTH));
  assign empty   = (count_r == LW'(0));
  assign level   = count_r;

endmodule

// File: rtl/skylark_fetch_unit.sv
// skylark_fetch_unit
//   Instruction fetch front end: issues word fetches to instruction memory,
//   collects in-order responses into a prefetch queue and presents the head
//   to decode as InstrF/PCF.
//   Parameters: DEPTH (queue entries), RESET_PC, MAX_OUTSTANDING.
//   Ports:
//     clk, reset                       : core clock, async active-low reset
//     imem_req/imem_addr/imem_gnt      : fetch request channel
//     imem_rvalid/imem_rdata           : in-order response channel
//     redirect_valid/redirect_pc       : taken branch/jump, flush and refetch
//     StallF                           : decode stall, head held while high
//     instr_valid/InstrF/PCF           : queue head presented to decode
//     level                            : queue occupancy
//   Optional feature macro SKYLARK_FETCH_PERF_EN adds saturating counters
//   perf_fetched (instructions consumed) and perf_discarded (responses dropped).
module skylark_fetch_unit
  import skylark_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     StallF,
  output logic                     instr_valid,
  output logic [31:0]              InstrF,
  output logic [31:0]              PCF,
`ifdef SKYLARK_FETCH_PERF_EN
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_discarded,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = LVL_W + 1;

  fetch_state_e   state_r;
  fetch_state_e   stateNext_s;
  logic [31:0]    fetchPc_r;
  logic [31:0]    respPc_r;
  logic [CNT_W-1:0] outstanding_r;
  logic [CNT_W-1:0] outstandingNext_s;
  logic [CNT_W-1:0] discard_r;
  logic [CNT_W-1:0] discardNext_s;

  logic           grant_s;
  logic           dropResp_s;
  logic           pushResp_s;
  logic           pop_s;
  logic           roomOk_s;
  fetch_entry_t   pushEntry_s;
  fetch_entry_t   head_s;
  logic           fifoFull_s;
  logic           fifoEmpty_s;

  // Room exists when queued plus in-flight entries leave a free slot for every
  // response, so a response can never be refused by the queue.
  assign roomOk_s = ((SUM_W'(level) + SUM_W'(outstanding_r)) < SUM_W'(DEPTH)) &&
                    (outstanding_r < CNT_W'(MAX_OUTSTANDING)) &&
                    !fifoFull_s;

  // FSM next state and request output.
  always_comb begin
    stateNext_s = state_r;
    imem_req    = 1'b0;
    case (state_r)
      RESET_WAIT: begin
        imem_req    = 1'b0;
        stateNext_s = RUN;
      end
      RUN: begin
        imem_req = roomOk_s;
        if (discardNext_s != CNT_W'(0)) begin
          stateNext_s = DRAIN;
        end else begin
          stateNext_s = RUN;
        end
      end
      DRAIN: begin
        imem_req = roomOk_s;
        if (discardNext_s == CNT_W'(0)) begin
          stateNext_s = RUN;
        end else begin
          stateNext_s = DRAIN;
        end
      end
      default: begin
        imem_req    = 1'b0;
        stateNext_s = RESET_WAIT;
      end
    endcase
  end

  assign grant_s   = imem_req & imem_gnt;
  assign imem_addr = fetchPc_r;

  // A response is dropped when it belongs to a flushed stream: either it
  // arrives with the redirect itself or the discard counter is still running.
  always_comb begin
    dropResp_s = 1'b0;
    pushResp_s = 1'b0;
    if (imem_rvalid) begin
      if (redirect_valid || (discard_r != CNT_W'(0))) begin
        dropResp_s = 1'b1;
      end else begin
        pushResp_s = 1'b1;
      end
    end else begin
      dropResp_s = 1'b0;
      pushResp_s = 1'b0;
    end
  end

  // In-flight and discard accounting; on redirect every request still in
  // flight after this edge (including one granted now) is old-stream.
  always_comb begin
    outstandingNext_s = outstanding_r;
    discardNext_s     = discard_r;
    case ({grant_s, imem_rvalid})
      2'b10:   outstandingNext_s = outstanding_r + CNT_W'(1);
      2'b01: begin
        if (outstanding_r != CNT_W'(0)) begin
          outstandingNext_s = outstanding_r - CNT_W'(1);
        end else begin
          outstandingNext_s = outstanding_r;
        end
      end
      default: outstandingNext_s = outstanding_r;
    endcase
    if (redirect_valid) begin
      discardNext_s = outstandingNext_s;
    end else if (imem_rvalid && (discard_r != CNT_W'(0))) begin
      discardNext_s = discard_r - CNT_W'(1);
    end else begin
      discardNext_s = discard_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RESET_WAIT;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Fetch/response address tracking and request counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc_r     <= RESET_PC;
      respPc_r      <= RESET_PC;
      outstanding_r <= '0;
      discard_r     <= '0;
    end else begin
      outstanding_r <= outstandingNext_s;
      discard_r     <= discardNext_s;
      if (redirect_valid) begin
        fetchPc_r <= alignWord(redirect_pc);
        respPc_r  <= alignWord(redirect_pc);
      end else begin
        // 32-bit adds wrap naturally past 32'hFFFF_FFFC.
        if (grant_s) begin
          fetchPc_r <= fetchPc_r + 32'd4;
        end
        if (pushResp_s) begin
          respPc_r <= respPc_r + 32'd4;
        end
      end
    end
  end

  assign pop_s       = !fifoEmpty_s && !StallF && !redirect_valid;
  assign pushEntry_s = '{pc: respPc_r, instr: imem_rdata};

  skylark_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (pushResp_s),
    .pushData (pushEntry_s),
    .pop      (pop_s),
    .popData  (head_s),
    .full     (fifoFull_s),
    .empty    (fifoEmpty_s),
    .level    (level)
  );

  // Head presentation; an empty queue shows a NOP at the next expected PC.
  always_comb begin
    instr_valid = !fifoEmpty_s;
    InstrF      = NOP_INSTR;
    PCF         = respPc_r;
    if (!fifoEmpty_s) begin
      InstrF = head_s.instr;
      PCF    = head_s.pc;
    end else begin
      InstrF = NOP_INSTR;
      PCF    = respPc_r;
    end
  end

`ifdef SKYLARK_FETCH_PERF_EN
  logic [31:0] perfFetched_r;
  logic [31:0] perfDiscarded_r;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perfFetched_r   <= 32'd0;
      perfDiscarded_r <= 32'd0;
    end else begin
      if (pop_s && (perfFetched_r != 32'hFFFF_FFFF)) begin
        perfFetched_r <= perfFetched_r + 32'd1;
      end
      if (dropResp_s && (perfDiscarded_r != 32'hFFFF_FFFF)) begin
        perfDiscarded_r <= perfDiscarded_r + 32'd1;
      end
    end
  end

  assign perf_fetched   = perfFetched_r;
  assign perf_discarded = perfDiscarded_r;
`endif

endmodule
